// File: rtl/imem_pkg.sv
// Shared definitions for the banked instruction memory, its fetch stage and assembler tooling.
package imem_pkg;

  localparam int unsigned ImemIw       = 9;
  localparam int unsigned ImemAw       = 8;
  localparam int unsigned ImemNumBanks = 4;
  localparam logic [ImemIw-1:0] ImemHaltWord = '1;

  typedef enum logic {
    IDLE,
    LOAD
  } ld_state_t;

  // What the registered fetch result should show in the cycle after a request.
  typedef enum logic [1:0] {
    FkNone,
    FkHalt,
    FkMem
  } fetch_kind_t;

endpackage

// File: rtl/instr_mem_banked_if.sv
// Loader and fetch signals of the banked instruction memory; master drives requests.
interface instr_mem_banked_if
  import imem_pkg::*;
#(
  parameter int unsigned IW = ImemIw,
  parameter int unsigned AW = ImemAw,
  parameter int unsigned BW = (ImemNumBanks > 1) ? $clog2(ImemNumBanks) : 1
);

  logic [BW-1:0] bank_sel;
  logic          load_start;
  logic          load_valid;
  logic [IW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          load_done;
  logic          busy;
  logic          fetch_en;
  logic [AW-1:0] pc;
  logic [IW-1:0] instr;
  logic          instr_valid;

  modport master (
    output bank_sel, load_start, load_valid, load_data, load_last, fetch_en, pc,
    input  load_ready, load_done, busy, instr, instr_valid
  );

  modport slave (
    input  bank_sel, load_start, load_valid, load_data, load_last, fetch_en, pc,
    output load_ready, load_done, busy, instr, instr_valid
  );

endinterface

// File: rtl/imem_bank_array.sv
// Banked program storage: one write port, one registered read port, no reset on contents.
module imem_bank_array #(
  parameter int unsigned IW        = 9,
  parameter int unsigned AW        = 8,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned BW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [BW-1:0] wbank_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [BW-1:0] rbank_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** (BW + AW);

  logic [IW-1:0] mem_q [Depth];
  logic [IW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[{wbank_i, waddr_i}] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[{rbank_i, raddr_i}];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_banked.sv
// Writable banked instruction memory: run-time loader FSM, per-bank length tracking and a
// registered fetch port that returns HALT_WORD beyond a bank's loaded length.
module instr_mem_banked
  import imem_pkg::*;
#(
  parameter int unsigned    IW        = ImemIw,
  parameter int unsigned    AW        = ImemAw,
  parameter int unsigned    NUM_BANKS = ImemNumBanks,
  parameter int unsigned    BW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  parameter logic [IW-1:0]  HALT_WORD = {IW{1'b1}}
) (
  input logic               clk,
  input logic               reset,
  instr_mem_banked_if.slave bus
);

  ld_state_t     state_q, state_d;
  logic [BW-1:0] ld_bank_q;
  logic [AW-1:0] wptr_q;
  logic [AW:0]   len_q [NUM_BANKS];
  logic          done_q;
  fetch_kind_t   kind_q, kind_d;
  logic [IW-1:0] instr_q;
  logic [IW-1:0] instr_cur;
  logic [IW-1:0] rdata;

  logic beat;
  logic exit_load;
  logic fetch_blocked;
  logic fetch_oob;

  assign beat      = (state_q == LOAD) && bus.load_valid;
  // A full bank ends the load on its last slot regardless of load_last.
  assign exit_load = beat && (bus.load_last || (wptr_q == {AW{1'b1}}));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.load_start) state_d = LOAD;
      LOAD:    if (exit_load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.load_ready = (state_q == LOAD);
    bus.busy       = (state_q == LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_bank_q <= '0;
      wptr_q    <= '0;
      done_q    <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        len_q[b] <= '0;
      end
    end else begin
      done_q <= exit_load;
      if ((state_q == IDLE) && bus.load_start) begin
        ld_bank_q              <= bus.bank_sel;
        wptr_q                 <= '0;
        len_q[bus.bank_sel]    <= '0;
      end else if (beat) begin
        if (exit_load) begin
          len_q[ld_bank_q] <= {1'b0, wptr_q} + (AW + 1)'(1);
        end else begin
          wptr_q <= wptr_q + AW'(1);
        end
      end
    end
  end

  assign bus.load_done = done_q;

  // Length/blocking decisions use pre-edge state, so a same-cycle load_start cannot affect them.
  assign fetch_blocked = (state_q == LOAD) && (bus.bank_sel == ld_bank_q);
  assign fetch_oob     = ({1'b0, bus.pc} >= len_q[bus.bank_sel]);

  always_comb begin
    kind_d = FkNone;
    if (bus.fetch_en && !fetch_blocked) begin
      kind_d = fetch_oob ? FkHalt : FkMem;
    end
  end

  imem_bank_array #(
    .IW        (IW),
    .AW        (AW),
    .NUM_BANKS (NUM_BANKS),
    .BW        (BW)
  ) u_bank_array (
    .clk_i   (clk),
    .we_i    (beat),
    .wbank_i (ld_bank_q),
    .waddr_i (wptr_q),
    .wdata_i (bus.load_data),
    .re_i    (kind_d == FkMem),
    .rbank_i (bus.bank_sel),
    .raddr_i (bus.pc),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      kind_q  <= FkNone;
      instr_q <= '0;
    end else begin
      kind_q  <= kind_d;
      instr_q <= instr_cur;
    end
  end

  // instr_q remembers the last presented word so non-updating cycles hold it.
  always_comb begin
    unique case (kind_q)
      FkMem:   instr_cur = rdata;
      FkHalt:  instr_cur = HALT_WORD;
      default: instr_cur = instr_q;
    endcase
  end

  assign bus.instr       = instr_cur;
  assign bus.instr_valid = (kind_q != FkNone);

endmodule

// File: tb/tb_instr_mem_banked.sv
// Randomised scoreboard bench for instr_mem_banked against a behavioural bank/length model.
module tb_instr_mem_banked;

  typedef struct packed {
    logic       v;
    logic [8:0] instr;
    logic       ready;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_mem_banked_if bus ();

  instr_mem_banked dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  exp_t       expq [$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc_n = 0;

  // Reference model: plain arrays of programs and lengths.
  logic [8:0] m_mem [4][256];
  int         m_len [4];
  bit         m_loading;
  int         m_ld;
  int         m_wptr;
  logic [8:0] m_last;

  task automatic step();
    exp_t e;
    int   b;
    int   p;
    b = int'(bus.bank_sel);
    p = int'(bus.pc);
    e = '0;
    if (rst) begin
      m_loading = 1'b0;
      m_wptr    = 0;
      m_last    = '0;
      for (int i = 0; i < 4; i++) m_len[i] = 0;
    end else begin
      if (bus.fetch_en && !(m_loading && b == m_ld)) begin
        e.v     = 1'b1;
        e.instr = (p >= m_len[b]) ? 9'h1FF : m_mem[b][p];
      end else begin
        e.instr = m_last;
      end
      m_last = e.instr;
      if (!m_loading) begin
        if (bus.load_start) begin
          m_loading = 1'b1;
          m_ld      = b;
          m_wptr    = 0;
          m_len[b]  = 0;
        end
      end else if (bus.load_valid) begin
        m_mem[m_ld][m_wptr] = bus.load_data;
        if (bus.load_last || m_wptr == 255) begin
          m_len[m_ld] = m_wptr + 1;
          m_loading   = 1'b0;
          e.done      = 1'b1;
        end else begin
          m_wptr++;
        end
      end
      e.ready = m_loading;
      e.busy  = m_loading;
    end
    expq.push_back(e);
    @(negedge clk);
  endtask

  task automatic cyc(input bit ls, input bit lv, input logic [8:0] d, input bit last,
                     input bit fe, input int bank, input int pc);
    bus.load_start = ls;
    bus.load_valid = lv;
    bus.load_data  = d;
    bus.load_last  = last;
    bus.fetch_en   = fe;
    bus.bank_sel   = 2'(bank);
    bus.pc         = 8'(pc);
    step();
  endtask

  task automatic idle();
    cyc(0, 0, 9'h000, 0, 0, 0, 0);
  endtask

  task automatic fetch(input int bank, input int pc);
    cyc(0, 0, 9'h000, 0, 1, bank, pc);
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk);
      #1;
      cyc_n++;
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        got = '{v: bus.instr_valid, instr: bus.instr, ready: bus.load_ready,
                busy: bus.busy, done: bus.load_done};
        n_vec++;
        if (got !== e) begin
          n_err++;
          $display("FAIL cycle %0d outputs: got v=%b instr=%h ready=%b busy=%b done=%b, want v=%b instr=%h ready=%b busy=%b done=%b",
                   cyc_n, got.v, got.instr, got.ready, got.busy, got.done,
                   e.v, e.instr, e.ready, e.busy, e.done);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    rst = 1'b1;
    bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0; bus.load_last = 0;
    bus.fetch_en = 0; bus.bank_sel = '0; bus.pc = '0;
    @(negedge clk);
    repeat (3) idle();
    rst = 1'b0;
    fetch(0, 0);

    // Short program into bank 1 with a two-cycle gap in the beat stream.
    cyc(1, 0, 9'h000, 0, 0, 1, 0);
    cyc(0, 1, 9'h001, 0, 0, 1, 0);
    cyc(0, 1, 9'h0A5, 0, 0, 1, 0);
    idle();
    idle();
    cyc(0, 1, 9'h1FE, 1, 0, 1, 0);
    idle();
    for (int i = 0; i < 4; i++) fetch(1, i);
    cyc(0, 0, 9'h000, 0, 0, 1, 4);

    // load_start and fetch of the same bank together: fetch sees old contents.
    cyc(1, 0, 9'h000, 0, 1, 1, 1);
    cyc(0, 1, 9'h123, 1, 0, 1, 0);
    fetch(1, 0);
    fetch(1, 1);
    cyc(0, 1, 9'h055, 1, 0, 0, 0);

    // Full bank 2 without load_last, interleaving blocked and unblocked fetches.
    cyc(1, 0, 9'h000, 0, 0, 2, 0);
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(3) == 0) begin
        cyc(0, 0, 9'h000, 0, 1, $urandom_range(1) ? 2 : 1, $urandom_range(3));
      end
      cyc(0, 1, 9'($urandom), 0, $urandom_range(1), $urandom_range(1) ? 2 : 1,
          $urandom_range(3));
    end
    idle();
    fetch(2, 255);
    fetch(2, 0);
    fetch(1, 0);

    // Random mixed traffic across all banks.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(19) == 0, $urandom_range(1), 9'($urandom), $urandom_range(15) == 0,
          $urandom_range(1), $urandom_range(3),
          ($urandom_range(3) == 0) ? $urandom_range(255) : $urandom_range(7));
    end

    guard = 0;
    while (m_loading && guard < 300) begin
      cyc(0, 1, 9'($urandom), 1, 0, 0, 0);
      guard++;
    end

    // Reset in the middle of a load empties every bank.
    cyc(1, 0, 9'h000, 0, 0, 3, 0);
    cyc(0, 1, 9'h011, 0, 0, 3, 0);
    cyc(0, 1, 9'h022, 0, 0, 3, 0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    for (int b = 0; b < 4; b++) fetch(b, 0);
    fetch(2, 255);
    idle();

    @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
